decode_stage_sb: RTL

Second-generation decode stage. Pairs the existing combinational Decoder with a parametrised NUMREGISTERS x DATAW register file, write-through bypass and a per-register scoreboard. Issues decoded operands through a registered valid/ready ID/EX boundary with RAW-hazard stalling, flush and halt latching. Sits between fetch (in_*) and execute (out_*), with writeback returning on wb_*.

---
 rtl/decode_stage_sb.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_sb.sv
// -----------------------------------------------------------------------------
// decode_stage_sb
//
// Decode stage with register file, write-through bypass and a per-register
// scoreboard. Fetched instructions are decoded combinationally, checked for
// RAW hazards, and issued through a registered valid/ready ID/EX boundary.
//
// Instruction layout (default parameters, INSTRW = 16):
//   [15:11] opcode   [10:8] rd   [7:5] rs1 (reg1)   [4:2] rs2 (reg2)
//   [1:0]   shift    imm = instr[IMMW-1:0]
//
// Opcodes -> control bits set:
//   01 ADD  reg_wr_en            02 SUB  reg_wr_en, alu_op
//   03 ADDI reg_wr_en, use_imm   04 ST   mem_wr_en
//   05 BR   branch, use_imm      06 FFTW fft_wr_en
//   07 SET  set_en, use_imm      08 SYN  syn
//   09 SETF set_freq, use_imm    1F HALT halt
//   others: all zero (NOP)
//
// out_ctrl = {halt, alu_op, reg_wr_en, mem_wr_en, branch, fft_wr_en,
//             set_en, syn, use_imm, set_freq}  (bit 9 .. bit 0)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     fetch handshake, instr = instruction word
//   flush                 kill output entry and scoreboard, block accept
//   wb_en/wb_reg/wb_data  writeback port into the register file
//   out_valid/out_ready   execute handshake
//   out_ctrl/out_shift/out_imm/out_rd/out_a/out_b  issued entry
//   halted                a halt has been issued; stage frozen until rst
//
// Optional feature macro: ZERO_REG_EN (register 0 hardwired to zero).
// -----------------------------------------------------------------------------
module decode_stage_sb #(
    parameter int DATAW        = 32,
    parameter int INSTRW       = 16,
    parameter int IMMW         = 11,
    parameter int NUMREGISTERS = 8,
    parameter int REGW         = 3,
    parameter int RD_LSB       = 8,
    parameter int PENDW        = 2,
    parameter int CTRLW        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSTRW-1:0] instr,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REGW-1:0]   wb_reg,
    input  logic [DATAW-1:0]  wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRLW-1:0]  out_ctrl,
    output logic [1:0]        out_shift,
    output logic [IMMW-1:0]   out_imm,
    output logic [REGW-1:0]   out_rd,
    output logic [DATAW-1:0]  out_a,
    output logic [DATAW-1:0]  out_b,
    output logic              halted
);

`ifdef ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    localparam int OPW     = INSTRW - (RD_LSB + REGW);
    localparam int RS1_LSB = 5;
    localparam int RS2_LSB = 2;
    localparam logic [PENDW-1:0] PEND_MAX = '1;

    localparam int C_HALT     = 9;
    localparam int C_ALU      = 8;
    localparam int C_REG_WR   = 7;
    localparam int C_MEM_WR   = 6;
    localparam int C_BRANCH   = 5;
    localparam int C_FFT_WR   = 4;
    localparam int C_SET_EN   = 3;
    localparam int C_SYN      = 2;
    localparam int C_USE_IMM  = 1;
    localparam int C_SET_FREQ = 0;

    // ---------------- decoder ----------------
    logic [OPW-1:0]   opcode;
    logic [REGW-1:0]  rs1, rs2, rd_idx;
    logic [CTRLW-1:0] dec_ctrl;

    assign opcode = instr[INSTRW-1 -: OPW];
    assign rs1    = instr[RS1_LSB +: REGW];
    assign rs2    = instr[RS2_LSB +: REGW];
    assign rd_idx = instr[RD_LSB +: REGW];

    always_comb begin
        dec_ctrl = '0;
        case (opcode)
            OPW'(8'h01): dec_ctrl[C_REG_WR] = 1'b1;
            OPW'(8'h02): begin dec_ctrl[C_REG_WR] = 1'b1; dec_ctrl[C_ALU] = 1'b1; end
            OPW'(8'h03): begin dec_ctrl[C_REG_WR] = 1'b1; dec_ctrl[C_USE_IMM] = 1'b1; end
            OPW'(8'h04): dec_ctrl[C_MEM_WR] = 1'b1;
            OPW'(8'h05): begin dec_ctrl[C_BRANCH] = 1'b1; dec_ctrl[C_USE_IMM] = 1'b1; end
            OPW'(8'h06): dec_ctrl[C_FFT_WR] = 1'b1;
            OPW'(8'h07): begin dec_ctrl[C_SET_EN] = 1'b1; dec_ctrl[C_USE_IMM] = 1'b1; end
            OPW'(8'h08): dec_ctrl[C_SYN] = 1'b1;
            OPW'(8'h09): begin dec_ctrl[C_SET_FREQ] = 1'b1; dec_ctrl[C_USE_IMM] = 1'b1; end
            OPW'(8'h1F): dec_ctrl[C_HALT] = 1'b1;
            default: ;
        endcase
    end

    // ---------------- state ----------------
    logic [DATAW-1:0]                   rf_q [NUMREGISTERS];
    logic [NUMREGISTERS-1:0][PENDW-1:0] pend_q, pend_d;
    logic                               out_valid_q, out_valid_d;
    logic                               halted_q, halted_d;
    logic [CTRLW-1:0]                   out_ctrl_q;
    logic [1:0]                         out_shift_q;
    logic [IMMW-1:0]                    out_imm_q;
    logic [REGW-1:0]                    out_rd_q;
    logic [DATAW-1:0]                   out_a_q, out_b_q;

    logic                               out_hs;
    logic [NUMREGISTERS-1:0][DATAW-1:0] rd_val;
    logic [NUMREGISTERS-1:0]            reg_haz, rf_we, sb_inc, sb_dec;

    assign out_hs = out_valid_q && out_ready;

    // Per-register read/bypass, hazard and scoreboard update.
    // The entry sitting in the output register is not yet counted in the
    // scoreboard (it is counted on its handshake), so it is checked directly.
    genvar gi;
    generate
        for (gi = 0; gi < NUMREGISTERS; gi++) begin : g_reg
            if (ZERO_EN && gi == 0) begin : g_zero
                assign rd_val[gi]  = '0;
                assign reg_haz[gi] = 1'b0;
                assign rf_we[gi]   = 1'b0;
                assign sb_inc[gi]  = 1'b0;
                assign sb_dec[gi]  = 1'b0;
            end else begin : g_norm
                logic wb_hit, out_hit;
                assign wb_hit  = wb_en && (wb_reg == REGW'(gi));
                assign out_hit = out_valid_q && out_ctrl_q[C_REG_WR] && (out_rd_q == REGW'(gi));
                assign rd_val[gi]  = wb_hit ? wb_data : rf_q[gi];
                // A single outstanding write that is returning right now is
                // satisfied by the bypass, so it does not stall.
                assign reg_haz[gi] = ((pend_q[gi] != '0) &&
                                      !((pend_q[gi] == PENDW'(1)) && wb_hit)) || out_hit;
                assign rf_we[gi]   = wb_hit;
                assign sb_inc[gi]  = out_hs && out_hit;
                assign sb_dec[gi]  = wb_hit && (pend_q[gi] != '0);
            end

            assign pend_d[gi] = flush                      ? '0 :
                                (sb_inc[gi] && !sb_dec[gi]) ? pend_q[gi] + PENDW'(1) :
                                (sb_dec[gi] && !sb_inc[gi]) ? pend_q[gi] - PENDW'(1) :
                                                              pend_q[gi];
        end
    endgenerate

    // ---------------- issue control ----------------
    logic hazard, cap_stall, accept;

    assign hazard = reg_haz[rs1] || (!dec_ctrl[C_USE_IMM] && reg_haz[rs2]);

    // A writer parked in the output register will bump the counter on its
    // handshake, so it is included to keep the counter from wrapping.
    assign cap_stall = dec_ctrl[C_REG_WR] &&
                       ((pend_q[rd_idx] == PEND_MAX) ||
                        ((pend_q[rd_idx] == PEND_MAX - PENDW'(1)) && out_valid_q &&
                         out_ctrl_q[C_REG_WR] && (out_rd_q == rd_idx)));

    assign in_ready = !rst && !halted_q && !flush && !hazard && !cap_stall &&
                      (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
        halted_d = halted_q || (accept && dec_ctrl[C_HALT]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            pend_q      <= '0;
            out_ctrl_q  <= '0;
            out_shift_q <= '0;
            out_imm_q   <= '0;
            out_rd_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            for (int r = 0; r < NUMREGISTERS; r++) begin
                rf_q[r] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            pend_q      <= pend_d;
            for (int r = 0; r < NUMREGISTERS; r++) begin
                if (rf_we[r]) begin
                    rf_q[r] <= wb_data;
                end
            end
            if (accept) begin
                out_ctrl_q  <= dec_ctrl;
                out_shift_q <= instr[1:0];
                out_imm_q   <= instr[IMMW-1:0];
                out_rd_q    <= rd_idx;
                out_a_q     <= rd_val[rs1];
                out_b_q     <= rd_val[rs2];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_shift = out_shift_q;
    assign out_imm   = out_imm_q;
    assign out_rd    = out_rd_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign halted    = halted_q;

endmodule
